// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a one-cycle-latency FIFO and packs RATIO words into each valid/ready output beat
module fifo_rd_packer #(
  parameter int FIFO_WIDTH = 16,
  parameter int RATIO = 2,
  parameter int OUT_WIDTH = FIFO_WIDTH * RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic                  underflow_err
);
  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);
  typedef enum logic [1:0] {FILL, FLUSH_WAIT, FLUSH_EMIT} state_t;
  state_t state_q, state_d;
  logic [RATIO-1:0][FIFO_WIDTH-1:0] acc_q, acc_d, m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] inflight;
  logic rd_pending_q, m_valid_q, m_valid_d, underflow_err_q, out_free;
  assign m_data = m_data_q;
  assign m_keep = m_keep_q;
  assign m_valid = m_valid_q;
  assign underflow_err = underflow_err_q;
  // Read gating counts the in-flight word so the accumulator can never overflow; capture, transfer and flush sequencing
  always_comb begin
    inflight = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pending_q};
    out_free = !m_valid_q || m_ready;
    fifo_rd_en = !rst && state_q == FILL && !fifo_empty && inflight < {1'b0, FULL};
    flush_done = 1'b0;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q + CW'(rd_pending_q);
    m_data_d = m_data_q;
    m_keep_d = m_keep_q;
    m_valid_d = m_valid_q && !m_ready;
    for (int i = 0; i < RATIO; i++)
      if (rd_pending_q && cnt_q == CW'(i)) acc_d[i] = fifo_data_out;
    if (cnt_q == FULL && out_free) begin
      m_data_d = acc_q;
      m_keep_d = '1;
      m_valid_d = 1'b1;
      cnt_d = '0;
    end
    case (state_q)
      FILL: state_d = flush ? FLUSH_WAIT : FILL;
      FLUSH_WAIT:
        if (!rd_pending_q && cnt_q != FULL) begin
          state_d = cnt_q == '0 ? FILL : FLUSH_EMIT;
          flush_done = !rst && cnt_q == '0;
        end
      FLUSH_EMIT:
        if (out_free) begin
          for (int i = 0; i < RATIO; i++) begin
            m_data_d[i] = CW'(i) < cnt_q ? acc_q[i] : '0;
            m_keep_d[i] = CW'(i) < cnt_q;
          end
          m_valid_d = 1'b1;
          cnt_d = '0;
          state_d = FILL;
          flush_done = !rst;
        end
      default: state_d = FILL;
    endcase
  end
  // State, accumulator and output register; reset drops held words and any in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q <= '0;
      cnt_q <= '0;
      rd_pending_q <= 1'b0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_valid_q <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rd_pending_q <= fifo_rd_en;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_valid_q <= m_valid_d;
      underflow_err_q <= underflow_err_q | fifo_underflow;
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: FIFO model plus stream scoreboard exercising packing, backpressure, flush and reset
module tb_fifo_rd_packer;
  localparam int FW = 16;
  localparam int R = 2;
  localparam int OW = FW * R;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_empty, fifo_rd_en, m_valid, flush_done, underflow_err;
  logic fifo_underflow = 1'b0;
  logic flush = 1'b0;
  logic m_ready = 1'b0;
  logic [FW-1:0] fifo_data_out = '0;
  logic [OW-1:0] m_data;
  logic [R-1:0] m_keep;
  int passed = 0;
  int total = 0;
  logic [FW-1:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  logic [FW-1:0] src [$];
  logic [OW+R-1:0] exp_q [$];
  logic [OW+R-1:0] obs_q [$];
  int fd_cnt = 0;
  int rd_viol = 0;
  logic do_rd = 1'b0;
  logic hold = 1'b0;
  logic [OW+R-1:0] held = '0;

  fifo_rd_packer #(.FIFO_WIDTH(FW), .RATIO(R)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready),
    .flush_done(flush_done), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;
  assign fifo_empty = (wp == rp);

  // FIFO model: a read accepted at an edge presents its word after that edge
  always @(negedge clk) do_rd = fifo_rd_en && !fifo_empty;
  always @(posedge clk)
    if (do_rd) begin
      fifo_data_out <= mem[rp % 1024];
      rp <= rp + 1;
    end

  // Monitor: records accepted beats, flush_done pulses, reads while empty and held-output stability
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol++;
    if (!rst && flush_done) fd_cnt++;
    if (hold && !rst) begin
      total++;
      if (m_valid === 1'b1 && {m_data, m_keep} === held) passed++;
      else $display("FAIL hold_stable: got valid=%b data=%h keep=%b, expected valid=1 data=%h keep=%b",
                    m_valid, m_data, m_keep, held[OW+R-1:R], held[R-1:0]);
    end
    hold = !rst && m_valid && !m_ready;
    held = {m_data, m_keep};
    if (!rst && m_valid && m_ready) obs_q.push_back({m_data, m_keep});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [FW-1:0] w);
    mem[wp % 1024] = w;
    wp++;
    src.push_back(w);
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    src.delete();
  endtask

  // Reference: n consecutive words from src, word 0 in the low lane, keep has the low n bits set
  function automatic logic [OW+R-1:0] model_pack(input int first, input int n);
    logic [OW-1:0] d = '0;
    logic [R-1:0] k = '0;
    for (int j = 0; j < n; j++) begin
      d[j*FW +: FW] = src[first+j];
      k[j] = 1'b1;
    end
    return {d, k};
  endfunction

  task automatic model_stream(input int first, input int n, input bit flushed);
    for (int i = 0; i < n; i += R)
      if (n - i >= R || flushed) exp_q.push_back(model_pack(first + i, (n - i >= R) ? R : n - i));
  endtask

  task automatic settle(output bit ok);
    int k = 0;
    while (obs_q.size() < exp_q.size() && k < 300) begin
      tick();
      k++;
    end
    ok = (k < 300);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({fifo_rd_en, m_valid, m_data, m_keep, flush_done, underflow_err} !== '0)
      $display("FAIL reset_values: got rd_en=%b valid=%b data=%h keep=%b done=%b err=%b, expected all 0",
               fifo_rd_en, m_valid, m_data, m_keep, flush_done, underflow_err);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int first_rd = -1;
    int first_v = -1;
    clear_sb();
    m_ready = 1'b1;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    model_stream(0, 4, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (first_rd < 0 && fifo_rd_en) first_rd = c;
      if (first_v < 0 && m_valid) first_v = c;
      tick();
    end
    settle(ok);
    total++;
    if (first_rd < 0 || first_v - first_rd != R + 2)
      $display("FAIL basic_latency: got %0d cycles, expected %0d", first_v - first_rd, R + 2);
    else passed++;
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL basic_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL basic_beat%0d: got %h/%b expected %h/%b", i, obs_q[i][OW+R-1:R], obs_q[i][R-1:0],
                 exp_q[i][OW+R-1:R], exp_q[i][R-1:0]);
      else passed++;
    end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0][OW+R-1:R] !== 32'h22221111)
        $display("FAIL basic_first: got %h expected 22221111", obs_q[0][OW+R-1:R]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_sb();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(FW'($urandom));
    model_stream(0, 6, 1'b0);
    repeat (10) tick();
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || {m_data, m_keep} !== exp_q[0])
      $display("FAIL bp_held: got valid=%b %h/%b expected valid=1 %h/%b", m_valid, m_data, m_keep,
               exp_q[0][OW+R-1:R], exp_q[0][R-1:0]);
    else passed++;
    total++;
    if (wp - rp != 2) $display("FAIL bp_remaining: got %0d words left, expected 2", wp - rp);
    else passed++;
    total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_stop: got rd_en=%b expected 0", fifo_rd_en);
    else passed++;
    tick();
    m_ready = 1'b1;
    settle(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL bp_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, obs_q[i][OW+R-1:R], obs_q[i][R-1:0],
                 exp_q[i][OW+R-1:R], exp_q[i][R-1:0]);
      else passed++;
    end
  endtask

  task automatic test_flush();
    bit ok;
    clear_sb();
    m_ready = 1'b1;
    push(16'hAAAA);
    push(16'hBBBB);
    push(16'hCCCC);
    model_stream(0, 3, 1'b1);
    repeat (10) tick();
    fd_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle(ok);
    total++;
    if (fd_cnt != 1) $display("FAIL flush_done_pulses: got %0d expected 1", fd_cnt);
    else passed++;
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL flush_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL flush_beat%0d: got %h/%b expected %h/%b", i, obs_q[i][OW+R-1:R], obs_q[i][R-1:0],
                 exp_q[i][OW+R-1:R], exp_q[i][R-1:0]);
      else passed++;
    end
    if (obs_q.size() == 2) begin
      total++;
      if (obs_q[1] !== {32'h0000CCCC, 2'b01})
        $display("FAIL flush_partial: got %h/%b expected 0000cccc/01", obs_q[1][OW+R-1:R], obs_q[1][R-1:0]);
      else passed++;
    end
  endtask

  task automatic test_empty_flush();
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (flush_done !== 1'b0) $display("FAIL eflush_early: got done=%b expected 0", flush_done);
    else passed++;
    tick();
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (flush_done !== 1'b1 || m_valid !== 1'b0)
      $display("FAIL eflush_done: got done=%b valid=%b expected done=1 valid=0", flush_done, m_valid);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (flush_done !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL eflush_after: got done=%b valid=%b expected 0 0", flush_done, m_valid);
    else passed++;
    tick();
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_sb();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(FW'($urandom));
    model_stream(2, 2, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if ({fifo_rd_en, m_valid, m_data, m_keep, flush_done, underflow_err} !== '0)
      $display("FAIL rst_mid_values: got rd_en=%b valid=%b data=%h keep=%b done=%b err=%b, expected all 0",
               fifo_rd_en, m_valid, m_data, m_keep, flush_done, underflow_err);
    else passed++;
    tick();
    rst = 1'b0;
    settle(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL rst_mid_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0] !== exp_q[0])
        $display("FAIL rst_mid_beat: got %h/%b expected %h/%b", obs_q[0][OW+R-1:R], obs_q[0][R-1:0],
                 exp_q[0][OW+R-1:R], exp_q[0][R-1:0]);
      else passed++;
    end
  endtask

  task automatic test_underflow();
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (underflow_err !== 1'b1) $display("FAIL underflow_sticky%0d: got %b expected 1", i, underflow_err);
      else passed++;
      tick();
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (underflow_err !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow_err);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit ok;
      int n;
      int k;
      clear_sb();
      fd_cnt = 0;
      n = $urandom_range(1, 9);
      k = 0;
      while (k < n) begin
        if ($urandom_range(0, 1) == 1) begin
          push(FW'($urandom));
          k++;
        end
        m_ready = 1'($urandom_range(0, 1));
        tick();
      end
      model_stream(0, n, 1'b1);
      k = 0;
      while (wp != rp && k < 300) begin
        m_ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      flush = 1'b1;
      m_ready = 1'($urandom_range(0, 1));
      tick();
      flush = 1'b0;
      m_ready = 1'b1;
      settle(ok);
      total++;
      if (k >= 300 || !ok || obs_q.size() != exp_q.size())
        $display("FAIL rand%0d_count: got %0d beats, expected %0d", it, obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", it, i, obs_q[i][OW+R-1:R],
                   obs_q[i][R-1:0], exp_q[i][OW+R-1:R], exp_q[i][R-1:0]);
        else passed++;
      end
      total++;
      if (fd_cnt != 1) $display("FAIL rand%0d_flush_done: got %0d pulses expected 1", it, fd_cnt);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_empty_flush();
    test_rst_mid();
    test_underflow();
    test_random();
    total++;
    if (rd_viol != 0) $display("FAIL read_while_empty: got %0d reads, expected 0", rd_viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the FIFO: drains FIFO_WIDTH-bit words through the FIFO's rd_en/data_out port and packs RATIO consecutive words into one OUT_WIDTH-bit word. The packed words leave on a valid/ready stream. The block sits directly downstream of the FIFO, honours its one-cycle read latency and never issues a read while the FIFO reports empty. A flush input forces out a partial word at end of stream.

## Interface
- FIFO_WIDTH, 16, FIFO word width; must match the FIFO instance.
- RATIO, 2, FIFO words per output word; legal range 2..8.
- OUT_WIDTH, FIFO_WIDTH*RATIO, derived; not to be overridden.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_rd_en  out  1  read request to the FIFO.
- flush  in  1  single-cycle pulse: emit any partial word.
- m_data  out  OUT_WIDTH  packed word; word 0 in bits [FIFO_WIDTH-1:0].
- m_keep  out  RATIO  per-lane valid mask.
- m_valid  out  1  m_data/m_keep valid.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- flush_done  out  1  one-cycle pulse when a flush completes.
- underflow_err  out  1  sticky error flag; cleared only by rst.

## Operation
- State: accumulator acc[RATIO] lanes; cnt (0..RATIO) words held; rd_pending (read issued last cycle); output register (m_data, m_keep, m_valid); FSM {FILL, FLUSH_WAIT, FLUSH_EMIT}.
- fifo_rd_en = !rst && state==FILL && !fifo_empty && (cnt + rd_pending < RATIO). This is combinational from registered state and fifo_empty.
- Capture: if rd_pending, fifo_data_out is written to lane cnt and cnt increments.
- Transfer: if cnt==RATIO and the output register is free (!m_valid || m_ready), acc moves to m_data, m_keep becomes all ones, m_valid becomes 1, cnt becomes 0.
  - No capture and no transfer occur in the same cycle; this follows from the read-gating rule.
- Output: m_valid drops on m_ready unless a new transfer loads it in the same cycle.
  - m_data and m_keep stay stable while m_valid && !m_ready.
- FILL, flush=1: go to FLUSH_WAIT. Reads stop immediately; the in-flight read, if any, is still captured.
- FLUSH_WAIT:
  - Full-word transfers continue as normal.
  - Once rd_pending==0 and cnt<RATIO:
    - cnt==0: pulse flush_done, go to FILL.
    - otherwise: go to FLUSH_EMIT.
- FLUSH_EMIT: when the output register is free, load it as follows, then pulse flush_done, clear cnt and go to FILL:
  - m_data gets acc, with unused lanes forced to 0.
  - m_keep gets the low cnt bits set.
  - m_valid gets 1.
- flush is ignored outside FILL.
- underflow_err is set on any cycle with fifo_underflow==1. This indicates a FIFO-side or protocol bug, since the block never reads while empty.
- Reset values: fifo_rd_en 0, m_valid 0, m_data 0, m_keep 0, flush_done 0, underflow_err 0, cnt 0, rd_pending 0, state FILL.
- Reset mid-operation discards held words and any in-flight read. The FIFO's own reset is separate.

## Timing
- FIFO read latency is 1 cycle: rd_en sampled high at edge N gives data at edge N+1.
- Steady-state throughput: RATIO words per RATIO+2 cycles. The bubble comes from the pending-read gating plus the transfer cycle.
- First m_valid comes RATIO+2 cycles after the first fifo_rd_en, with a non-empty FIFO and m_ready=1.
- Backpressure: with m_valid held, the accumulator still fills to RATIO, then reads stop; no data is lost.
- Flush latency: at most 2 cycles to FLUSH_EMIT, plus output-register wait. flush_done is asserted in the cycle the partial word loads, or the cycle the empty flush completes.

## Test plan
- RATIO=2, FIFO preloaded 0x1111, 0x2222, 0x3333, 0x4444, m_ready=1 -> m_data 0x22221111 then 0x44443333, m_keep 2'b11, no fifo_rd_en after empty.
- m_ready=0 for 10 cycles with FIFO holding 6 words -> first word held stable, cnt reaches 2, reads stop, 2 words remain in FIFO; release -> all 3 words in order.
- 3 words (0xAAAA, 0xBBBB, 0xCCCC) then flush -> 0xBBBBAAAA keep 11, then 0x0000CCCC keep 01, flush_done one pulse.
- flush with cnt==0 and no read in flight -> flush_done one cycle later, m_valid stays 0.
- rst asserted while rd_pending=1 and cnt=1 -> next cycle all outputs at reset values; the following words pack from lane 0.
- Inject fifo_underflow=1 for one cycle -> underflow_err stays 1 until rst.
